// File: rtl/adc_clk_sysref_ctrl.sv
// adc_clk_sysref_ctrl: forwarded-clock gating and SYSREF pulse generator for
// N ADC3424 chips. Produces ODDR D1/D2 data; ODDR/OBUFDS live outside.
// Optional build macro SYSREF_ALIGN_EN adds an ARM state that holds the first
// SYSREF rising edge until a free-running alignment counter wraps to 0.
module adc_clk_sysref_ctrl #(
    parameter int unsigned N_ADC        = 4,
    parameter int unsigned PERIOD_W     = 16,
    parameter int unsigned NPULSE_W     = 8,
    parameter int unsigned ALIGN_PERIOD = 64
) (
    input  logic                enc_clk,
    input  logic                rst,
    input  logic [N_ADC-1:0]    clk_en_mask,
    input  logic [N_ADC-1:0]    sysref_mask,
    input  logic                sysref_start,
    input  logic                sysref_stop,
    input  logic                sysref_mode,
    input  logic [PERIOD_W-1:0] sysref_half_period,
    input  logic [NPULSE_W-1:0] sysref_n_pulses,
    output logic [N_ADC-1:0]    adc_clk_d1,
    output logic [N_ADC-1:0]    adc_clk_d2,
    output logic [N_ADC-1:0]    sysrf_d1,
    output logic [N_ADC-1:0]    sysrf_d2,
    output logic                sysref_busy,
    output logic                sysref_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_ARM  = 2'd3
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] phase_cnt;
    logic [PERIOD_W-1:0] hp_r;
    logic [NPULSE_W-1:0] np_rem;
    logic                mode_r;
    logic                stop_pend;
    logic [N_ADC-1:0]    clk_en_r;

    logic [PERIOD_W-1:0] hp_in;
    logic [NPULSE_W-1:0] np_in;

    // Zero-valued fields are promoted to 1
    assign hp_in = (sysref_half_period == '0) ? PERIOD_W'(1) : sysref_half_period;
    assign np_in = (sysref_n_pulses == '0) ? NPULSE_W'(1) : sysref_n_pulses;

    // Clock enable is registered once; D1 stays low so D2 alone gates the clock
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            clk_en_r   <= '0;
            adc_clk_d1 <= '0;
        end else begin
            clk_en_r   <= clk_en_mask;
            adc_clk_d1 <= '0;
        end
    end

    assign adc_clk_d2 = clk_en_r;

`ifdef SYSREF_ALIGN_EN
    localparam int unsigned ALIGN_W = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    logic [ALIGN_W-1:0] align_cnt;

    // Free-running alignment grid counter, modulo ALIGN_PERIOD
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            align_cnt <= '0;
        end else if (align_cnt == ALIGN_W'(ALIGN_PERIOD - 1)) begin
            align_cnt <= '0;
        end else begin
            align_cnt <= align_cnt + ALIGN_W'(1);
        end
    end
`endif

    // SYSREF generator FSM; SYSREF outputs are loaded with the level of the next state
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            hp_r        <= '0;
            np_rem      <= '0;
            mode_r      <= 1'b0;
            stop_pend   <= 1'b0;
            sysrf_d1    <= '0;
            sysrf_d2    <= '0;
            sysref_busy <= 1'b0;
            sysref_done <= 1'b0;
        end else begin
            sysref_done <= 1'b0;
            sysrf_d1    <= '0;
            sysrf_d2    <= '0;
            case (state)
                S_IDLE: begin
                    if (sysref_start) begin
                        mode_r      <= sysref_mode;
                        hp_r        <= hp_in;
                        np_rem      <= np_in;
                        phase_cnt   <= hp_in - PERIOD_W'(1);
                        stop_pend   <= 1'b0;
                        sysref_busy <= 1'b1;
`ifdef SYSREF_ALIGN_EN
                        state       <= S_ARM;
`else
                        state       <= S_HIGH;
                        sysrf_d1    <= sysref_mask;
                        sysrf_d2    <= sysref_mask;
`endif
                    end
                end
`ifdef SYSREF_ALIGN_EN
                S_ARM: begin
                    if (sysref_stop) begin
                        state       <= S_IDLE;
                        sysref_busy <= 1'b0;
                        sysref_done <= 1'b1;
                    end else if (align_cnt == '0) begin
                        state    <= S_HIGH;
                        sysrf_d1 <= sysref_mask;
                        sysrf_d2 <= sysref_mask;
                    end
                end
`endif
                S_HIGH: begin
                    if (sysref_stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (phase_cnt == '0) begin
                        state     <= S_LOW;
                        phase_cnt <= hp_r - PERIOD_W'(1);
                    end else begin
                        phase_cnt <= phase_cnt - PERIOD_W'(1);
                        sysrf_d1  <= sysref_mask;
                        sysrf_d2  <= sysref_mask;
                    end
                end
                S_LOW: begin
                    if (sysref_stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - PERIOD_W'(1);
                    end else begin
                        if (!mode_r && (np_rem != '0)) begin
                            np_rem <= np_rem - NPULSE_W'(1);
                        end
                        if (stop_pend || sysref_stop ||
                            (!mode_r && (np_rem <= NPULSE_W'(1)))) begin
                            state       <= S_IDLE;
                            stop_pend   <= 1'b0;
                            sysref_busy <= 1'b0;
                            sysref_done <= 1'b1;
                        end else begin
                            state     <= S_HIGH;
                            phase_cnt <= hp_r - PERIOD_W'(1);
                            sysrf_d1  <= sysref_mask;
                            sysrf_d2  <= sysref_mask;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    sysref_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_clk_sysref_ctrl.sv
// Directed self-checking bench for adc_clk_sysref_ctrl (default build).
// The alignment test is compiled only when SYSREF_ALIGN_EN is defined.
module tb_adc_clk_sysref_ctrl;

    localparam int unsigned N_ADC    = 4;
    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned NPULSE_W = 8;

    logic                enc_clk = 1'b0;
    logic                rst;
    logic [N_ADC-1:0]    clk_en_mask;
    logic [N_ADC-1:0]    sysref_mask;
    logic                sysref_start;
    logic                sysref_stop;
    logic                sysref_mode;
    logic [PERIOD_W-1:0] sysref_half_period;
    logic [NPULSE_W-1:0] sysref_n_pulses;
    logic [N_ADC-1:0]    adc_clk_d1;
    logic [N_ADC-1:0]    adc_clk_d2;
    logic [N_ADC-1:0]    sysrf_d1;
    logic [N_ADC-1:0]    sysrf_d2;
    logic                sysref_busy;
    logic                sysref_done;

    int n_tests = 0;
    int n_fail  = 0;

    adc_clk_sysref_ctrl #(
        .N_ADC(N_ADC), .PERIOD_W(PERIOD_W), .NPULSE_W(NPULSE_W), .ALIGN_PERIOD(64)
    ) dut (
        .enc_clk(enc_clk), .rst(rst),
        .clk_en_mask(clk_en_mask), .sysref_mask(sysref_mask),
        .sysref_start(sysref_start), .sysref_stop(sysref_stop),
        .sysref_mode(sysref_mode), .sysref_half_period(sysref_half_period),
        .sysref_n_pulses(sysref_n_pulses),
        .adc_clk_d1(adc_clk_d1), .adc_clk_d2(adc_clk_d2),
        .sysrf_d1(sysrf_d1), .sysrf_d2(sysrf_d2),
        .sysref_busy(sysref_busy), .sysref_done(sysref_done)
    );

    always #5 enc_clk = ~enc_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; returns 1 ns after the edge so outputs are settled
    task automatic tick();
        @(posedge enc_clk);
        #1;
    endtask

    // Check SYSREF outputs, busy and done against an expected level/mask
    task automatic check_gen(input string tag, input logic lvl, input logic [N_ADC-1:0] msk,
                             input logic busy, input logic done);
        logic [N_ADC-1:0] e;
        e = lvl ? msk : '0;
        check({tag, ".d1"}, 32'(sysrf_d1), 32'(e));
        check({tag, ".d2"}, 32'(sysrf_d2), 32'(e));
        check({tag, ".busy"}, 32'(sysref_busy), 32'(busy));
        check({tag, ".done"}, 32'(sysref_done), 32'(done));
    endtask

    task automatic start_gen(input logic mode, input int hp, input int np);
        sysref_mode        = mode;
        sysref_half_period = PERIOD_W'(hp);
        sysref_n_pulses    = NPULSE_W'(np);
        sysref_start       = 1'b1;
        tick();
        sysref_start       = 1'b0;
    endtask

    initial begin
        int  edges;
        int  cyc;
        logic prev;

        rst = 1'b1; clk_en_mask = '0; sysref_mask = '0;
        sysref_start = 1'b0; sysref_stop = 1'b0; sysref_mode = 1'b0;
        sysref_half_period = '0; sysref_n_pulses = '0;
        repeat (3) tick();

        // Reset state
        check("rst.clk_d1", 32'(adc_clk_d1), 32'(0));
        check("rst.clk_d2", 32'(adc_clk_d2), 32'(0));
        check_gen("rst", 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Clock gating: one-cycle latency, D1 held low
        clk_en_mask = 4'b0101;
        check("gate.before", 32'(adc_clk_d2), 32'(4'b0000));
        tick();
        check("gate.d2_0101", 32'(adc_clk_d2), 32'(4'b0101));
        check("gate.d1", 32'(adc_clk_d1), 32'(0));
        clk_en_mask = 4'b1010;
        tick();
        check("gate.d2_1010", 32'(adc_clk_d2), 32'(4'b1010));

        // Burst hp=3 np=2: HHH LLL HHH LLL then done
        sysref_mask = 4'b1111;
        start_gen(1'b0, 3, 2);
        for (int i = 0; i < 14; i++) begin
            check_gen($sformatf("burst%0d", i), (i < 3) || (i >= 6 && i < 9), 4'b1111,
                      i < 12, i == 12);
            tick();
        end

        // Continuous hp=2, stop in second HIGH: pulse completes, one LOW, done
        sysref_mask = 4'b0110;
        start_gen(1'b1, 2, 0);
        for (int i = 0; i < 11; i++) begin
            check_gen($sformatf("cont%0d", i), (i < 2) || (i == 4) || (i == 5), 4'b0110,
                      i < 8, i == 8);
            if (i == 4) sysref_stop = 1'b1;
            tick();
            sysref_stop = 1'b0;
        end

        // Zero fields -> one 1-cycle pulse; start while busy ignored
        sysref_mask = 4'b1111;
        start_gen(1'b0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            check_gen($sformatf("zero%0d", i), i == 0, 4'b1111, i < 2, i == 2);
            if (i == 0) sysref_start = 1'b1;
            tick();
            sysref_start = 1'b0;
        end

        // Stop in IDLE ignored; start+stop together: start wins, full 2-pulse burst
        sysref_stop = 1'b1;
        tick();
        sysref_stop = 1'b1;
        start_gen(1'b0, 1, 2);
        sysref_stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_gen($sformatf("ss%0d", i), (i == 0) || (i == 2), 4'b1111, i < 4, i == 4);
            tick();
        end

        // Mask applied with one-cycle latency while HIGH
        start_gen(1'b0, 4, 1);
        sysref_mask = 4'b1001;
        check_gen("mask.old", 1'b1, 4'b1111, 1'b1, 1'b0);
        tick();
        check_gen("mask.new", 1'b1, 4'b1001, 1'b1, 1'b0);
        repeat (8) tick();
        sysref_mask = 4'b1111;

        // Reset mid-burst with a pending stop: outputs cleared, no done, stop forgotten
        start_gen(1'b0, 3, 2);
        sysref_stop = 1'b1;
        tick();
        sysref_stop = 1'b0;
        rst = 1'b1;
        tick();
        check_gen("rstmid", 1'b0, '0, 1'b0, 1'b0);
        check("rstmid.clk_d2", 32'(adc_clk_d2), 32'(0));
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_gen($sformatf("post_rst%0d", i), 1'b0, '0, 1'b0, 1'b0);
        end
        start_gen(1'b1, 1, 0);
        repeat (6) tick();
        check("nostop.busy", 32'(sysref_busy), 32'(1));
        sysref_stop = 1'b1;
        tick();
        sysref_stop = 1'b0;
        cyc = 0;
        while (!sysref_done && cyc < 10) begin
            tick();
            cyc++;
        end
        check("nostop.done", 32'(sysref_done), 32'(1));

        // Maximum pulse count: 255 pulses then done, bounded wait
        tick();
        start_gen(1'b0, 1, 255);
        edges = 0; prev = 1'b0; cyc = 0;
        while (!sysref_done && cyc < 600) begin
            if (sysrf_d1[0] && !prev) edges++;
            prev = sysrf_d1[0];
            tick();
            cyc++;
        end
        check("np255.done", 32'(sysref_done), 32'(1));
        check("np255.edges", 32'(edges), 32'(255));
        check("np255.cycles", 32'(cyc), 32'(510));

`ifdef SYSREF_ALIGN_EN
        // Alignment: start at counter=10, first high the cycle after counter=0
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        start_gen(1'b0, 1, 1);
        for (int k = 0; k < 54; k++) begin
            check_gen($sformatf("arm%0d", k), 1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        check_gen("arm.high", 1'b1, 4'b1111, 1'b1, 1'b0);
        repeat (3) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
